time_set_ctrl: RTL and testbench

Mode and sequencing controller for the FPGA digital clock. It debounces the raw `slct` and `up` push-buttons and runs the RUN / SET_HR / SET_MIN / SET_SEC mode FSM. It generates the 1 Hz count tick and issues single-cycle increment commands to the hour/min/sec counter datapath. It is the only block allowed to advance or adjust the time registers.

---
 rtl/time_ctrl_pkg.sv | 35 +++
 rtl/time_set_ctrl_btn_debounce.sv | 66 ++++++
 rtl/time_set_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_ctrl_pkg.sv
// time_ctrl_pkg
//   Shared definitions for the digital clock: mode encodings used by the
//   mode FSM and the display, field limits shared with the hour/min/sec
//   counter datapath, and small elaboration helpers.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10,
    MODE_SET_SEC = 2'b11
  } mode_e;

  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned SEC_MAX = 59;

  // RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    case (m)
      MODE_RUN:     r = MODE_SET_HR;
      MODE_SET_HR:  r = MODE_SET_MIN;
      MODE_SET_MIN: r = MODE_SET_SEC;
      default:      r = MODE_RUN;
    endcase
    return r;
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// btn_debounce
//   Push-button conditioner: 2-flop synchronizer, debounce counter and
//   rising-edge event on the debounced level.
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-low reset
//     raw   in   raw asynchronous button
//     level out  debounced button level
//     evt   out  one-cycle pulse on a debounced rising edge
//   A button already held when reset is released produces no event until
//   it has been seen released at least once.
module btn_debounce
  import time_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic evt
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          valid1;
  logic          valid2;
  logic          armed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      evt    <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      // valid2 marks when sync2 holds a real post-reset sample
      valid1 <= 1'b1;
      valid2 <= valid1;
      evt    <= 1'b0;
      if (valid2 && !sync2) begin
        armed <= 1'b1;
      end
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        evt   <= sync2 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Mode and sequencing controller for the digital clock: debounces the
//   slct/up buttons, runs the RUN/SET_HR/SET_MIN/SET_SEC mode FSM, makes the
//   1 Hz tick and issues single-cycle increment pulses to the time datapath.
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous active-low reset
//     slct     in   raw mode button
//     up       in   raw increment button
//     tick     out  one-cycle pulse per second, RUN only
//     inc_hr   out  hour += 1 pulse
//     inc_min  out  minute += 1 pulse
//     inc_sec  out  second += 1 pulse
//     mode     out  00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//     blink    out  field-flash enable, 0 in RUN
//   Build option: define TIME_SET_AUTOREPEAT_EN for hold-to-repeat on up.
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 100_000_000,
  parameter int unsigned DEBOUNCE_CYC     = 2_000_000,
  parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slct,
  input  logic       up,
  output logic       tick,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       inc_sec,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned TW = cnt_width(CLK_HZ);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam int unsigned BLINK_HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int unsigned BW = cnt_width(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic    slct_level;
  logic    slct_evt;
  logic    up_level;
  logic    up_evt;
  logic    up_take;
  logic    rpt_fire;
  logic    inc_req;
  logic    unused_sink;

  mode_e   state;
  mode_e   state_next;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_slct_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (slct),
    .level (slct_level),
    .evt   (slct_evt)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_up_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (up),
    .level (up_level),
    .evt   (up_evt)
  );

  assign mode = state;

  // Mode FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MODE_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (slct_evt) begin
      state_next = next_mode(state);
    end
  end

  // A press counts only in a SET state and loses to a coincident slct event.
  assign up_take = up_evt && !slct_evt && (state != MODE_RUN);

`ifdef TIME_SET_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX =
    (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int unsigned RW = cnt_width(RPT_MAX);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

  logic          rpt_on;
  logic          rpt_first;
  logic [RW-1:0] rpt_cnt;

  // Counter restarts at the accepted press; the first interval is the
  // delay, later ones the rate.
  assign rpt_fire = rpt_on && up_level && !slct_evt &&
                    (rpt_cnt == (rpt_first ? DELAY_LAST : RATE_LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rpt_on    <= 1'b0;
      rpt_first <= 1'b0;
      rpt_cnt   <= '0;
    end else if (slct_evt) begin
      rpt_on <= 1'b0;
    end else if (up_take) begin
      rpt_on    <= 1'b1;
      rpt_first <= 1'b1;
      rpt_cnt   <= '0;
    end else if (rpt_on) begin
      if (!up_level) begin
        rpt_on <= 1'b0;
      end else if (rpt_fire) begin
        rpt_first <= 1'b0;
        rpt_cnt   <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end

  assign unused_sink = slct_level;
`else
  assign rpt_fire    = 1'b0;
  assign unused_sink = ^{slct_level, up_level, REPEAT_DELAY_CYC, REPEAT_RATE_CYC};
`endif

  assign inc_req = up_take || rpt_fire;

  // Registered outputs: tick prescaler, blink divider, increment pulses.
  // Prescaler and divider run only while the mode stays put on their side
  // of RUN, so entering/leaving RUN clears them and suppresses stray pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick      <= 1'b0;
      inc_hr    <= 1'b0;
      inc_min   <= 1'b0;
      inc_sec   <= 1'b0;
      blink     <= 1'b0;
      tick_cnt  <= '0;
      blink_cnt <= '0;
    end else begin
      inc_hr  <= inc_req && (state == MODE_SET_HR);
      inc_min <= inc_req && (state == MODE_SET_MIN);
      inc_sec <= inc_req && (state == MODE_SET_SEC);

      if (state == MODE_RUN && state_next == MODE_RUN) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          tick     <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
          tick     <= 1'b0;
        end
      end else begin
        tick_cnt <= '0;
        tick     <= 1'b0;
      end

      if (state != MODE_RUN && state_next != MODE_RUN) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
//   Directed bench for time_set_ctrl with scaled timing. A behavioural model
//   derives every output from raw button history and mode/time arithmetic;
//   a compare process checks all outputs each cycle, and directed scenarios
//   pin pulse counts, mode values and pulse spacing with literal values.
module tb_time_set_ctrl;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned DEB    = 4;
  localparam int unsigned DELAY  = 20;
  localparam int unsigned RATE   = 5;
  localparam int unsigned HALF   = CLK_HZ / 2;
  localparam int HLEN = 4096;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       slct = 1'b0;
  logic       up   = 1'b0;
  logic       tick, inc_hr, inc_min, inc_sec, blink;
  logic [1:0] mode;

  time_set_ctrl #(
    .CLK_HZ           (CLK_HZ),
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (DELAY),
    .REPEAT_RATE_CYC  (RATE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .slct    (slct),
    .up      (up),
    .tick    (tick),
    .inc_hr  (inc_hr),
    .inc_min (inc_min),
    .inc_sec (inc_sec),
    .mode    (mode),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   rs [0:HLEN-1];
  bit   ru [0:HLEN-1];
  int   n = 0;
  int   r = -100;
  bit   valid = 1'b0;
  bit   lvl_s, lvl_u, arm_s, arm_u, ev_s, ev_u, rpt;
  int   run_start, set_start, press_edge;
  logic [1:0] m_mode;
  bit   m_tick, m_hr, m_min, m_sec, m_blink;

  // Synchronized view of a button at edge e: raw sampled two edges earlier,
  // zero until the synchronizer has refilled after reset.
  function automatic bit samp(input bit sel, input int e);
    if (e - 2 <= r || e - 2 < 0 || e - 2 >= HLEN) return 1'b0;
    return sel ? ru[e-2] : rs[e-2];
  endfunction

  // Level flips once DEB consecutive post-reset samples disagree with it.
  function automatic bit flip_now(input bit sel, input bit lvl, input int e);
    for (int k = 0; k < int'(DEB); k++) begin
      if (e - k <= r || samp(sel, e - k) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    logic [1:0] nm;
    bit sl, ue, fire, fs, fu;
    if (n < HLEN) begin
      rs[n] = slct;
      ru[n] = up;
    end
    if (!rst) begin
      r = n; valid = 1'b1;
      m_mode = 2'd0; m_tick = 0; m_hr = 0; m_min = 0; m_sec = 0; m_blink = 0;
      lvl_s = 0; lvl_u = 0; arm_s = 0; arm_u = 0; ev_s = 0; ev_u = 0; rpt = 0;
      run_start = n; set_start = n; press_edge = n;
    end else begin
      sl = ev_s;
      ue = ev_u;
      nm = sl ? m_mode + 2'd1 : m_mode;
      m_tick = (m_mode == 2'd0) && (nm == 2'd0) && (((n - run_start) % int'(CLK_HZ)) == 0);
      if (m_mode != 2'd0 && nm != 2'd0)
        m_blink = ((((n - set_start) / int'(HALF)) % 2) == 1);
      else
        m_blink = 1'b0;
      if (m_mode != 2'd0 && nm == 2'd0) run_start = n;
      if (m_mode == 2'd0 && nm != 2'd0) set_start = n;
      fire = 1'b0;
      if (m_mode != 2'd0 && !sl && ue) begin
        fire = 1'b1;
        press_edge = n;
`ifdef TIME_SET_AUTOREPEAT_EN
        rpt = 1'b1;
`endif
      end else if (rpt) begin
        if (sl || !lvl_u) rpt = 1'b0;
        else if (n - press_edge >= int'(DELAY) &&
                 ((n - press_edge - int'(DELAY)) % int'(RATE)) == 0) fire = 1'b1;
      end
      m_hr  = fire && (m_mode == 2'd1);
      m_min = fire && (m_mode == 2'd2);
      m_sec = fire && (m_mode == 2'd3);
      m_mode = nm;
      fs = flip_now(1'b0, lvl_s, n);
      fu = flip_now(1'b1, lvl_u, n);
      ev_s = fs && !lvl_s && arm_s;
      ev_u = fu && !lvl_u && arm_u;
      if (n - 2 > r && !samp(1'b0, n)) arm_s = 1'b1;
      if (n - 2 > r && !samp(1'b1, n)) arm_u = 1'b1;
      if (fs) lvl_s = !lvl_s;
      if (fu) lvl_u = !lvl_u;
    end
    n++;
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("tick",    {31'b0, tick},    {31'b0, m_tick});
      chk("inc_hr",  {31'b0, inc_hr},  {31'b0, m_hr});
      chk("inc_min", {31'b0, inc_min}, {31'b0, m_min});
      chk("inc_sec", {31'b0, inc_sec}, {31'b0, m_sec});
      chk("mode",    {30'b0, mode},    {30'b0, m_mode});
      chk("blink",   {31'b0, blink},   {31'b0, m_blink});
    end
  end

  // ---------------- directed stimulus ----------------
  int cyc_no = 0;
  int c_tick, c_hr, c_min, c_sec;
  int hr_at [0:15];

  task automatic clr();
    c_tick = 0; c_hr = 0; c_min = 0; c_sec = 0;
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      cyc_no++;
      if (tick) c_tick++;
      if (inc_min) c_min++;
      if (inc_sec) c_sec++;
      if (inc_hr) begin
        if (c_hr < 16) hr_at[c_hr] = cyc_no;
        c_hr++;
      end
    end
  endtask

  task automatic press_slct(input int hold, input int gap);
    slct = 1'b1;
    cyc(hold);
    slct = 1'b0;
    cyc(gap);
  endtask

  initial begin
    bit found;
    int k;

    // reset and idle
    rst = 1'b0; slct = 1'b0; up = 1'b0;
    cyc(3);
    chk("reset_mode", {30'b0, mode}, 32'd0);
    chk("reset_outs", {27'b0, tick, inc_hr, inc_min, inc_sec, blink}, 32'd0);
    rst = 1'b1;
    clr();
    cyc(35);
    chk("idle_ticks", c_tick, 32'd3);
    chk("idle_incs", c_hr + c_min + c_sec, 32'd0);

    // mode cycling
    for (int i = 1; i <= 3; i++) begin
      press_slct(10, 12);
      chk("mode_step", {30'b0, mode}, i);
    end
    slct = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (mode == 2'd0) found = 1'b1;
    end
    chk("mode_back_run", {31'b0, found}, 32'd1);
    k = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(1);
      k++;
      if (tick) found = 1'b1;
    end
    chk("tick_resume_gap", k, 32'd10);
    slct = 1'b0;
    cyc(12);

    // bounce rejection in SET_MIN
    press_slct(10, 12);
    press_slct(10, 12);
    chk("mode_set_min", {30'b0, mode}, 32'd2);
    clr();
    up = 1; cyc(2); up = 0; cyc(2);
    up = 1; cyc(2); up = 0; cyc(2);
    up = 1; cyc(3); up = 0; cyc(12);
    chk("bounce_no_inc", c_min, 32'd0);
    up = 1; cyc(6); up = 0; cyc(12);
    chk("press6_one_inc", c_min, 32'd1);

    // hold in SET_HR
    press_slct(10, 12);
    press_slct(10, 12);
    press_slct(10, 12);
    chk("mode_set_hr", {30'b0, mode}, 32'd1);
    clr();
    up = 1; cyc(40); up = 0; cyc(15);
`ifdef TIME_SET_AUTOREPEAT_EN
    chk("hold_inc_count", c_hr, 32'd5);
    chk("rpt_gap1", hr_at[1] - hr_at[0], 32'd20);
    chk("rpt_gap2", hr_at[2] - hr_at[0], 32'd25);
    chk("rpt_gap3", hr_at[3] - hr_at[0], 32'd30);
    chk("rpt_gap4", hr_at[4] - hr_at[0], 32'd35);
`else
    chk("hold_inc_count", c_hr, 32'd1);
`endif

    // simultaneous slct/up in SET_SEC
    press_slct(10, 12);
    press_slct(10, 12);
    chk("mode_set_sec", {30'b0, mode}, 32'd3);
    clr();
    slct = 1; up = 1; cyc(10);
    slct = 0; up = 0; cyc(12);
    chk("simul_mode", {30'b0, mode}, 32'd0);
    chk("simul_no_inc", c_sec, 32'd0);

    // reset during a hold
    press_slct(10, 12);
    up = 1; cyc(30);
    rst = 0; cyc(1);
    chk("midhold_rst_mode", {30'b0, mode}, 32'd0);
    chk("midhold_rst_outs", {27'b0, tick, inc_hr, inc_min, inc_sec, blink}, 32'd0);
    rst = 1; cyc(10);
    clr();
    press_slct(10, 12);
    chk("post_rst_set_hr", {30'b0, mode}, 32'd1);
    cyc(30);
    chk("held_through_rst", c_hr, 32'd0);
    up = 0; cyc(12);
    up = 1; cyc(6); up = 0; cyc(12);
    chk("repress_inc", c_hr, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
